// File: rtl/split_pkg.sv
// -----------------------------------------------------------------------------
// split_pkg
// Shared definitions for the split_2o frame router.
//   state_e   : routing state, ST_OUT1 feeds output 1, ST_OUT2 feeds output 2.
//   cnt_width : bit width needed for a counter covering 0..n-1 (at least 1).
// -----------------------------------------------------------------------------
package split_pkg;

    typedef enum logic {
        ST_OUT1 = 1'b0,
        ST_OUT2 = 1'b1
    } state_e;

    // A counter over n values needs $clog2(n) bits; n == 1 still needs one
    // bit so the vector is never zero-width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/split_frame_cnt.sv
// -----------------------------------------------------------------------------
// split_frame_cnt
// Pixel-in-frame and frame-in-section counters for split_2o.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   inc_i            : one pixel accepted this cycle
//   sel_limit_i      : index of the last frame of the current section
//   pix_cnt_o        : pixel index within the frame, 0..D*D-1
//   ch_cnt_o         : frame index within the section, 0..CH_MAX-1
//   frame_last_o     : current pixel is the last of its frame
//   section_last_o   : current frame is the last of its section
// A section ends on the pixel where frame_last_o and section_last_o are both high.
// -----------------------------------------------------------------------------
module split_frame_cnt
    import split_pkg::*;
#(
    parameter int D      = 299,
    parameter int CH_MAX = 1,
    localparam int PIX_W = cnt_width(D * D),
    localparam int CH_W  = cnt_width(CH_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic [CH_W-1:0]  sel_limit_i,
    output logic [PIX_W-1:0] pix_cnt_o,
    output logic [CH_W-1:0]  ch_cnt_o,
    output logic             frame_last_o,
    output logic             section_last_o
);

    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(D * D - 1);

    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]  ch_cnt_q,  ch_cnt_d;

    assign frame_last_o   = (pix_cnt_q == PIX_MAX);
    assign section_last_o = (ch_cnt_q == sel_limit_i);

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        if (inc_i) begin
            if (frame_last_o) begin
                pix_cnt_d = '0;
                ch_cnt_d  = section_last_o ? '0 : ch_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
        end
    end

    assign pix_cnt_o = pix_cnt_q;
    assign ch_cnt_o  = ch_cnt_q;

endmodule

// File: rtl/split_2o.sv
// -----------------------------------------------------------------------------
// split_2o
// Routes whole D*D-pixel frames of one valid-qualified stream to two outputs:
// CH_1 frames to output 1, then CH_2 frames to output 2, repeating.
// Latency is one cycle; the unselected output keeps its last pixel value.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   valid_in, pxl_in         : input pixel stream (no backpressure)
//   valid_out_1, pxl_out_1   : branch 1 stream
//   valid_out_2, pxl_out_2   : branch 2 stream
//   group_done               : pulse with the last pixel of a CH_1+CH_2 group
//   last_out_1, last_out_2   : last-pixel-of-frame flags (SPLIT_LAST_EN only)
// Build option: define SPLIT_LAST_EN to add the last_out_k ports.
// -----------------------------------------------------------------------------
module split_2o
    import split_pkg::*;
#(
    parameter int D          = 299,
    parameter int CH_1       = 1,
    parameter int CH_2       = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  valid_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic                  valid_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic                  group_done
`ifdef SPLIT_LAST_EN
    ,
    output logic                  last_out_1,
    output logic                  last_out_2
`endif
);

    localparam int CH_MAX = (CH_1 > CH_2) ? CH_1 : CH_2;
    localparam int PIX_W  = cnt_width(D * D);
    localparam int CH_W   = cnt_width(CH_MAX);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       sel_limit;
    logic [PIX_W-1:0]      pix_cnt;
    logic [CH_W-1:0]       ch_cnt;
    logic                  frame_last;
    logic                  section_last;
    logic                  section_end;

    logic                  valid_1_q, valid_1_d;
    logic                  valid_2_q, valid_2_d;
    logic [DATA_WIDTH-1:0] pxl_1_q,   pxl_1_d;
    logic [DATA_WIDTH-1:0] pxl_2_q,   pxl_2_d;
    logic                  done_q,    done_d;
`ifdef SPLIT_LAST_EN
    logic                  last_1_q,  last_1_d;
    logic                  last_2_q,  last_2_d;
`endif

    assign sel_limit   = (state_q == ST_OUT1) ? CH_W'(CH_1 - 1) : CH_W'(CH_2 - 1);
    assign section_end = frame_last & section_last;

    split_frame_cnt #(
        .D      (D),
        .CH_MAX (CH_MAX)
    ) u_frame_cnt (
        .clk            (clk),
        .reset          (reset),
        .inc_i          (valid_in),
        .sel_limit_i    (sel_limit),
        .pix_cnt_o      (pix_cnt),
        .ch_cnt_o       (ch_cnt),
        .frame_last_o   (frame_last),
        .section_last_o (section_last)
    );

    // The routing decision uses the current state, so the pixel that ends a
    // section still leaves on the old port and the switch takes effect for
    // the next accepted pixel.
    always_comb begin
        state_d   = state_q;
        valid_1_d = 1'b0;
        valid_2_d = 1'b0;
        pxl_1_d   = pxl_1_q;
        pxl_2_d   = pxl_2_q;
        done_d    = 1'b0;
`ifdef SPLIT_LAST_EN
        last_1_d  = 1'b0;
        last_2_d  = 1'b0;
`endif
        if (valid_in) begin
            unique case (state_q)
                ST_OUT1: begin
                    valid_1_d = 1'b1;
                    pxl_1_d   = pxl_in;
`ifdef SPLIT_LAST_EN
                    last_1_d  = frame_last;
`endif
                    if (section_end) state_d = ST_OUT2;
                end
                ST_OUT2: begin
                    valid_2_d = 1'b1;
                    pxl_2_d   = pxl_in;
`ifdef SPLIT_LAST_EN
                    last_2_d  = frame_last;
`endif
                    if (section_end) begin
                        state_d = ST_OUT1;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OUT1;
            valid_1_q <= 1'b0;
            valid_2_q <= 1'b0;
            pxl_1_q   <= '0;
            pxl_2_q   <= '0;
            done_q    <= 1'b0;
`ifdef SPLIT_LAST_EN
            last_1_q  <= 1'b0;
            last_2_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            valid_1_q <= valid_1_d;
            valid_2_q <= valid_2_d;
            pxl_1_q   <= pxl_1_d;
            pxl_2_q   <= pxl_2_d;
            done_q    <= done_d;
`ifdef SPLIT_LAST_EN
            last_1_q  <= last_1_d;
            last_2_q  <= last_2_d;
`endif
        end
    end

    // The counter's flags must always agree with the counts it reports.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (frame_last == (pix_cnt == PIX_W'(D * D - 1)));
            assert (section_last == (ch_cnt == sel_limit));
        end
    end

    assign valid_out_1 = valid_1_q;
    assign pxl_out_1   = pxl_1_q;
    assign valid_out_2 = valid_2_q;
    assign pxl_out_2   = pxl_2_q;
    assign group_done  = done_q;
`ifdef SPLIT_LAST_EN
    assign last_out_1  = last_1_q;
    assign last_out_2  = last_2_q;
`endif

endmodule

// File: tb/tb_split_2o.sv
// -----------------------------------------------------------------------------
// tb_split_2o
// Self-checking bench for split_2o with a small frame (D=3) and unequal
// section lengths (CH_1=2, CH_2=3). The reference model works from the
// global index of each accepted pixel: frame = idx / (D*D), group slot =
// frame mod (CH_1+CH_2), port 1 for the first CH_1 slots, port 2 otherwise.
// Build option: SPLIT_LAST_EN also checks last_out_1/last_out_2.
// -----------------------------------------------------------------------------
module tb_split_2o;

    localparam int D    = 3;
    localparam int CH_1 = 2;
    localparam int CH_2 = 3;
    localparam int DW   = 32;
    localparam int DD   = D * D;
    localparam int G    = CH_1 + CH_2;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic          valid_out_1;
    logic [DW-1:0] pxl_out_1;
    logic          valid_out_2;
    logic [DW-1:0] pxl_out_2;
    logic          group_done;
`ifdef SPLIT_LAST_EN
    logic          last_out_1;
    logic          last_out_2;
`endif

    always #5 clk = ~clk;

    split_2o #(
        .D          (D),
        .CH_1       (CH_1),
        .CH_2       (CH_2),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .pxl_in      (pxl_in),
        .valid_out_1 (valid_out_1),
        .pxl_out_1   (pxl_out_1),
        .valid_out_2 (valid_out_2),
        .pxl_out_2   (pxl_out_2),
        .group_done  (group_done)
`ifdef SPLIT_LAST_EN
        ,
        .last_out_1  (last_out_1),
        .last_out_2  (last_out_2)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    int unsigned k;          // accepted pixels since the last reset
    logic [DW-1:0] exp_p1;
    logic [DW-1:0] exp_p2;
    int unsigned   n_in;     // accepted inputs since last reset
    int unsigned   n_out;    // observed output valids since last reset
    logic [DW-1:0] seq;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int port_of(input int unsigned idx);
        return (((idx / DD) % G) < CH_1) ? 1 : 2;
    endfunction

    // Apply one cycle of stimulus, then compare all outputs against the model.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        logic          ev1, ev2, edone, el1, el2, lastpix;
        int            pt;
        @(negedge clk);
        reset    = r;
        valid_in = v;
        pxl_in   = d;
        @(posedge clk);
        #1;
        ev1 = 1'b0; ev2 = 1'b0; edone = 1'b0; el1 = 1'b0; el2 = 1'b0;
        if (r) begin
            k      = 0;
            exp_p1 = '0;
            exp_p2 = '0;
            n_in   = 0;
            n_out  = 0;
        end else if (v) begin
            pt      = port_of(k);
            lastpix = ((k % DD) == DD - 1);
            if (pt == 1) begin
                ev1    = 1'b1;
                exp_p1 = d;
                el1    = lastpix;
            end else begin
                ev2    = 1'b1;
                exp_p2 = d;
                el2    = lastpix;
                edone  = lastpix && (((k / DD) % G) == G - 1);
            end
            k++;
            n_in++;
        end
        if (!r) n_out += int'(valid_out_1) + int'(valid_out_2);
        check("valid_out_1", DW'(valid_out_1), DW'(ev1));
        check("valid_out_2", DW'(valid_out_2), DW'(ev2));
        check("pxl_out_1",   pxl_out_1, exp_p1);
        check("pxl_out_2",   pxl_out_2, exp_p2);
        check("group_done",  DW'(group_done), DW'(edone));
        check("one_hot",     DW'(valid_out_1 & valid_out_2), '0);
`ifdef SPLIT_LAST_EN
        check("last_out_1",  DW'(last_out_1), DW'(el1));
        check("last_out_2",  DW'(last_out_2), DW'(el2));
`endif
    endtask

    initial begin
        logic reached;
        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = '0;
        seq      = 32'd1;

        // Reset state, including a pixel offered during reset
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 32'hdead_beef, 1'b1);

        // Two full groups with continuous valid, sequential pixel values
        for (int i = 0; i < 2 * G * DD; i++) begin
            drive(1'b1, seq, 1'b0);
            seq++;
        end

        // Random idle gaps and random data; order must be unchanged
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(2, 0) == 0) drive(1'b1, $urandom, 1'b0);
            else                           drive(1'b0, $urandom, 1'b0);
        end
        check("count_in_eq_out", n_out, n_in);

        // Run to pixel index 5 inside an out2 frame, then reset with valid high
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (port_of(k) == 2 && (k % DD) == 5) reached = 1'b1;
            else drive(1'b1, $urandom, 1'b0);
        end
        check("reach_reset_point", DW'(reached), DW'(1'b1));
        drive(1'b1, 32'h5555_aaaa, 1'b1);

        // After reset: pixel 0 of frame 0 goes to out1, then normal pattern
        for (int i = 0; i < G * DD + 4; i++) drive(1'b1, $urandom, 1'b0);

        // Back-to-back section switch with interleaved idles
        for (int i = 0; i < 120; i++) drive(1'(i % 3 != 1), $urandom, 1'b0);
        check("count_in_eq_out_2", n_out, n_in);

        drive(1'b0, '0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/split_2o.md
Name: split_2o

Overview:
- Inverse of the two-input channel merge: takes one valid-qualified 32-bit pixel stream and routes whole frames to one of two output streams.
- Each frame is D*D pixels in raster order.
- The stream is a repeating group: the first CH_1 frames go to port 1, the next CH_2 frames go to port 2, then the pattern wraps.
- Sits after a merged/concatenated feature map so that branches can be fed separately.

Parameters:
- D, 299, frame side length in pixels (frame = D*D pixels); D >= 2.
- CH_1, 1, consecutive frames routed to output 1 per group; CH_1 >= 1.
- CH_2, 1, consecutive frames routed to output 2 per group; CH_2 >= 1.
- DATA_WIDTH, 32, pixel word width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  pxl_in carries a pixel this cycle.
- pxl_in  in  DATA_WIDTH  input pixel.
- valid_out_1  out  1  pxl_out_1 valid.
- pxl_out_1  out  DATA_WIDTH  pixel for branch 1.
- valid_out_2  out  1  pxl_out_2 valid.
- pxl_out_2  out  DATA_WIDTH  pixel for branch 2.
- group_done  out  1  one-cycle pulse with the last pixel of a full CH_1+CH_2 group.

Behaviour:
- Flow control and reset:
  - No backpressure; the source may insert idle cycles (valid_in=0) anywhere.
  - Reset (synchronous, active-high) clears all outputs, counters and state. State goes to ST_OUT1. Reset wins over a simultaneous valid_in.
- Latency: exactly 1 cycle. A pixel accepted at edge N appears on the selected output after edge N, with its valid high for exactly one cycle.
- Unselected output: valid low; pxl holds its last value (no zeroing).
- Idle cycles: both valids low, all counters and state hold.
- Counters:
  - pix_cnt: 0..D*D-1, width $clog2(D*D).
  - ch_cnt: 0..max(CH_1,CH_2)-1.
- State machine (advances only on accepted pixels):
  - ST_OUT1: route to output 1.
    - pix_cnt==D*D-1 and ch_cnt==CH_1-1: pix_cnt=0, ch_cnt=0, go to ST_OUT2.
    - pix_cnt==D*D-1 otherwise: pix_cnt=0, ch_cnt+1.
    - Otherwise: pix_cnt+1.
  - ST_OUT2: same rules with CH_2. On its final pixel, go to ST_OUT1 and assert group_done (registered, aligned with valid_out_2 of that pixel).
- Boundary conditions:
  - The frame-switch decision uses the current pixel. The pixel that completes a section still goes to the old output; the next accepted pixel goes to the new output, even with no idle cycle in between.
  - Mid-frame reset: the partial frame is discarded; the next accepted pixel is pixel 0 of frame 0 to output 1.
  - valid_in X or Z is not supported; the bench drives it to 0 before the first pixel.

Optional Feature:
- Macro: SPLIT_LAST_EN.
- Defined: adds outputs last_out_1 and last_out_2 (1 bit each). Each pulses high with valid_out_k on the final pixel (pix_cnt==D*D-1) of every frame routed to port k. Reset value 0.
- Undefined: these ports do not exist and no extra logic is built.

Decomposition:
- Package split_pkg:
  - State encoding ST_OUT1=1'b0, ST_OUT2=1'b1.
  - Function returning the counter width for a given frame size.
  - No hard-coded D.
- One sub-module, split_frame_cnt (parameters D and CH_MAX):
  - Inputs: inc, sel_limit.
  - Outputs: pix_cnt, ch_cnt, frame_last, section_last.
  - The top holds the FSM and output registers.

Test Plan:
- D=3, CH_1=1, CH_2=1, continuous valid, pixels 1..36 → pixels 1-9 on out1, 10-18 on out2, 19-27 on out1, 28-36 on out2, each one cycle after input; group_done pulses with pixels 18 and 36.
- D=3, CH_1=2, CH_2=1, 54 pixels → 1-18 out1, 19-27 out2, 28-45 out1, 46-54 out2; never both valids high in the same cycle.
- Same as the first test with valid_in toggling 1,0,0,1... → identical output order; valid counts equal input count; held pxl_out values unchanged during gaps.
- Reset asserted after pixel 5 of the out2 section, with valid_in=1 in the reset cycle → outputs 0 the next cycle; that pixel is dropped; the next pixel appears on out1; 9 pixels later it switches to out2.
- D=299 defaults, two frames of file data → 89401 words on each output matching the input halves; group_done once.
- SPLIT_LAST_EN defined, first test stimulus → last_out_1 high with pixels 9 and 27; last_out_2 high with 18 and 36.
